// File: rtl/alu_pkg.sv
// Shared op codes, FSM encodings and helpers for the multicycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic illegal;
    logic ovf;
    logic carry;
    logic sign;
    logic zero;
  } flags_t;

  function automatic bit width_legal(int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic bit is_iter(op_e o);
    return (o == OP_MUL) || (o == OP_MULHU) || (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  function automatic bit is_div(op_e o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
module mul_div_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;

  // hi:lo is product (MSB:LSB) for multiply, remainder:quotient for divide
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    if (start) begin
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
      div_d = is_div(op);
      cnt_d = CW'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CW'(1);
      // done flags the cycle whose closing edge performs the final step
      done_d = (cnt_q == CW'(2));
      if (div_q) begin
        if (rem_sh >= {1'b0, b_q}) begin
          hi_d = WIDTH'(rem_sh - {1'b0, b_q});
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = rem_sh[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[WIDTH:1];
        lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked ALU: single-cycle logic/arith ops inline, mul/div via mul_div_iter.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             illegal_op
);

  if (!width_legal(WIDTH)) begin : g_width_bad
    $error("multicycle_alu: WIDTH must be 8, 16, 32 or 64");
  end

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic             accept_c, md_start_c, md_done;
  logic [WIDTH-1:0] md_hi, md_lo, calc_res;
  flags_t           calc_flg;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;

  mul_div_iter #(.WIDTH(WIDTH)) u_mul_div (
    .clk   (clk),
    .rst   (rst),
    .start (md_start_c),
    .op    (op_e'(op)),
    .a     (src_a),
    .b     (src_b),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Result and flags from the latched request
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    shamt    = b_q[SHW-1:0];
    calc_res = '0;
    calc_flg = '0;
    case (op_q)
      OP_ADD: begin
        calc_res       = sum[WIDTH-1:0];
        calc_flg.carry = sum[WIDTH];
        calc_flg.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        calc_res       = diff[WIDTH-1:0];
        calc_flg.carry = ~diff[WIDTH];
        calc_flg.ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLL:   calc_res = a_q << shamt;
      OP_SLT:   calc_res = WIDTH'($signed(a_q) < $signed(b_q));
      OP_SLTU:  calc_res = WIDTH'(a_q < b_q);
      OP_XOR:   calc_res = a_q ^ b_q;
      OP_SRL:   calc_res = a_q >> shamt;
      OP_SRA:   calc_res = WIDTH'($signed(a_q) >>> shamt);
      OP_OR:    calc_res = a_q | b_q;
      OP_AND:   calc_res = a_q & b_q;
      OP_MUL:   calc_res = md_lo;
      OP_MULHU: calc_res = md_hi;
      OP_DIVU:  calc_res = md_lo;
      OP_REMU:  calc_res = md_hi;
      default:  calc_flg.illegal = 1'b1;
    endcase
    calc_flg.zero = (calc_res == '0);
    calc_flg.sign = calc_res[WIDTH-1];
  end

  // First DONE cycle registers the result; out_valid follows one edge later
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
    md_start_c  = 1'b0;
    accept_c    = in_valid && in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          op_d       = op_e'(op);
          a_d        = src_a;
          b_d        = src_b;
          md_start_c = is_iter(op_e'(op));
          state_d    = is_iter(op_e'(op)) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        if (md_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          result_d    = calc_res;
          flags_d     = calc_flg;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero_flag  = flags_q.zero;
  assign sign_flag  = flags_q.sign;
  assign carry_flag = flags_q.carry;
  assign ovf_flag   = flags_q.ovf;
  assign illegal_op = flags_q.illegal;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized + directed bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         zero_flag, sign_flag, carry_flag, ovf_flag, illegal_op;
  logic [3:0]   op;
  logic [W-1:0] src_a, src_b, result;
  logic [4:0]   flags;

  int unsigned  n_checks = 0;
  int unsigned  n_pass   = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [4:0]   flg;
  } exp_t;

  always #5 clk = ~clk;

  assign flags = {illegal_op, ovf_flag, carry_flag, sign_flag, zero_flag};

  multicycle_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag),
    .sign_flag  (sign_flag),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .illegal_op (illegal_op)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic, flags {illegal, ovf, carry, sign, zero}
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t              e;
    longint            sa, sb, s;
    longint unsigned   ua, ub, p;
    int                amt;
    logic              ill, v, c;
    e   = '0;
    ill = 1'b0;
    v   = 1'b0;
    c   = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    amt = int'(b[4:0]);
    case (o)
      4'd0: begin
        e.res = a + b;
        c     = (ua + ub) > 64'hFFFF_FFFF;
        s     = sa + sb;
        v     = s != longint'($signed(e.res));
      end
      4'd1: begin
        e.res = a - b;
        c     = (a >= b);
        s     = sa - sb;
        v     = s != longint'($signed(e.res));
      end
      4'd2:  e.res = a << amt;
      4'd3:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd5:  e.res = a ^ b;
      4'd6:  e.res = a >> amt;
      4'd7:  e.res = W'($signed(a) >>> amt);
      4'd8:  e.res = a | b;
      4'd9:  e.res = a & b;
      4'd10: begin p = ua * ub; e.res = p[31:0];  end
      4'd11: begin p = ua * ub; e.res = p[63:32]; end
      4'd12: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: e.res = (b == 0) ? a : a % b;
      default: ill = 1'b1;
    endcase
    e.flg = {ill, v, c, e.res[W-1], (e.res == 0)};
    return e;
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (!ok) check({tag, " ready_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input string tag);
    exp_t e;
    int   lat;
    bit   ok;
    e = model(o, a, b);
    wait_ready(tag, ok);
    if (!ok) return;
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    // scramble inputs after acceptance; the result must not follow them
    in_valid = 1'b0;
    op       = 4'($urandom);
    src_a    = $urandom;
    src_b    = $urandom;
    check({tag, " busy"}, {62'd0, in_ready, out_valid}, 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (o >= 4'd10 && o <= 4'd13) ? 64'd33 : 64'd1);
    check({tag, " result"}, 64'(result), 64'(e.res));
    check({tag, " flags"}, 64'(flags), 64'(e.flg));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " hold"}, 64'({out_valid, in_ready, result, flags}), 64'({1'b1, 1'b0, e.res, e.flg}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " release"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit          ok, seen;
    logic [3:0]  ro;
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    src_a     = '0;
    src_b     = '0;
    repeat (2) @(negedge clk);
    check("reset state", 64'({in_ready, out_valid, result, flags}), 64'({1'b1, 1'b0, 32'd0, 5'd0}));
    rst = 1'b0;

    run_op(4'd0,  32'hFFFF_FFFF, 32'd1,         0,  "add_wrap");
    run_op(4'd1,  32'h8000_0000, 32'd1,         0,  "sub_ovf");
    run_op(4'd7,  32'h8000_0000, 32'h24,        0,  "sra");
    run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 0,  "mul");
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 0,  "mulhu");
    run_op(4'd12, 32'd100,       32'd7,         1,  "divu");
    run_op(4'd13, 32'd100,       32'd7,         0,  "remu");
    run_op(4'd12, 32'd5,         32'd0,         0,  "divu_by0");
    run_op(4'd13, 32'd5,         32'd0,         0,  "remu_by0");
    run_op(4'd0,  32'h7FFF_FFFF, 32'd1,         10, "add_stall");
    run_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0, 0,  "ill15");
    run_op(4'd14, 32'h1,         32'h1,         2,  "ill14");

    // reset wins over a simultaneous request
    wait_ready("rst_prio", ok);
    rst      = 1'b1;
    in_valid = 1'b1;
    op       = 4'd0;
    src_a    = 32'd1;
    src_b    = 32'd2;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    seen     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen = 1'b1;
    end
    check("rst_prio no accept", 64'(seen), 64'd0);

    // reset in the middle of a divide aborts it
    wait_ready("abort", ok);
    in_valid = 1'b1;
    op       = 4'd12;
    src_a    = 32'd100;
    src_b    = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort state", 64'({in_ready, out_valid, result, flags}), 64'({1'b1, 1'b0, 32'd0, 5'd0}));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no result", 64'(seen), 64'd0);
    run_op(4'd13, 32'd1000, 32'd33, 0, "post_abort");

    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = ra;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
